// File: rtl/fp_adder_pkg.sv
// Shared constants and pipeline-boundary payloads for the streaming FP adder.
package fp_adder_pkg;

    localparam int unsigned FP_E_WIDTH = 8;
    localparam int unsigned FP_M_WIDTH = 23;
    localparam int unsigned FP_W       = FP_E_WIDTH + FP_M_WIDTH + 1;
    localparam int unsigned BIAS       = (1 << (FP_E_WIDTH - 1)) - 1;
    localparam int unsigned EXP_MAX    = (1 << FP_E_WIDTH) - 1;

    localparam logic [FP_W-1:0] QNAN = {1'b0, {FP_E_WIDTH{1'b1}}, 1'b1, {(FP_M_WIDTH-1){1'b0}}};

    // After unpack/align: both mantissas carry hidden, fraction, guard, round, sticky.
    typedef struct packed {
        logic                  sign;
        logic                  eff_sub;
        logic [FP_E_WIDTH-1:0] exp;
        logic [FP_M_WIDTH+3:0] m_big;
        logic [FP_M_WIDTH+3:0] m_small;
        logic                  nan;
        logic                  inf;
    } fp_s1_t;

    // After add/sub: one extra MSB holds the carry-out.
    typedef struct packed {
        logic                  sign;
        logic [FP_E_WIDTH-1:0] exp;
        logic [FP_M_WIDTH+4:0] sum;
        logic                  nan;
        logic                  inf;
    } fp_s2_t;

endpackage

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter; an all-zero input returns W.
module fp_lzc #(
    parameter int unsigned W  = 27,
    parameter int unsigned CW = $clog2(W + 1)
) (
    input  logic [W-1:0]  i_data,
    output logic [CW-1:0] o_cnt_c
);

    // Scan upward so the highest set bit has the final say.
    always_comb begin
        o_cnt_c = CW'(W);
        for (int i = 0; i < int'(W); i++) begin
            if (i_data[i]) begin
                o_cnt_c = CW'(int'(W) - 1 - i);
            end
        end
    end

endmodule

// File: rtl/fp_adder.sv
// Three-stage pipelined floating-point adder (unpack/align, add/sub, normalize/round/pack)
// behind an operand capture register; one result per clock, round to nearest even.
module fp_adder
    import fp_adder_pkg::*;
#(
    parameter int unsigned E_WIDTH = FP_E_WIDTH,
    parameter int unsigned M_WIDTH = FP_M_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [E_WIDTH+M_WIDTH:0]   A,
    input  logic [E_WIDTH+M_WIDTH:0]   B,
    output logic [E_WIDTH+M_WIDTH:0]   res
);

    localparam int unsigned W   = E_WIDTH + M_WIDTH + 1;
    localparam int unsigned MX  = M_WIDTH + 4;
    localparam int unsigned E1  = E_WIDTH + 1;
    localparam int unsigned LZW = $clog2(MX + 1);

    logic [W-1:0] r_a, r_b;
    fp_s1_t       r_s1;
    fp_s2_t       r_s2;

    // ---------------- stage 1: unpack, specials, swap, align ----------------
    logic [E_WIDTH-1:0] w_ea, w_eb, w_ea_eff, w_eb_eff, w_e_big, w_e_small, w_diff;
    logic [M_WIDTH-1:0] w_fa, w_fb;
    logic [M_WIDTH:0]   w_ma, w_mb, w_m_big, w_m_small;
    logic               w_sa, w_sb, w_s_big, w_a_big;
    logic               w_nan_a, w_nan_b, w_inf_a, w_inf_b, w_nan, w_inf;
    logic [MX-1:0]      w_ext, w_mask, w_shifted, w_aligned;
    fp_s1_t             w_s1;

    assign w_sa = r_a[W-1];
    assign w_sb = r_b[W-1];
    assign w_ea = r_a[W-2:M_WIDTH];
    assign w_eb = r_b[W-2:M_WIDTH];
    assign w_fa = r_a[M_WIDTH-1:0];
    assign w_fb = r_b[M_WIDTH-1:0];

    assign w_ea_eff = (w_ea == '0) ? E_WIDTH'(1) : w_ea;
    assign w_eb_eff = (w_eb == '0) ? E_WIDTH'(1) : w_eb;
    assign w_ma     = {|w_ea, w_fa};
    assign w_mb     = {|w_eb, w_fb};

    assign w_nan_a = (&w_ea) && (|w_fa);
    assign w_nan_b = (&w_eb) && (|w_fb);
    assign w_inf_a = (&w_ea) && !(|w_fa);
    assign w_inf_b = (&w_eb) && !(|w_fb);
    assign w_nan   = w_nan_a || w_nan_b || (w_inf_a && w_inf_b && (w_sa != w_sb));
    assign w_inf   = !w_nan && (w_inf_a || w_inf_b);

    assign w_a_big   = {w_ea_eff, w_ma} >= {w_eb_eff, w_mb};
    assign w_e_big   = w_a_big ? w_ea_eff : w_eb_eff;
    assign w_e_small = w_a_big ? w_eb_eff : w_ea_eff;
    assign w_m_big   = w_a_big ? w_ma : w_mb;
    assign w_m_small = w_a_big ? w_mb : w_ma;
    assign w_s_big   = w_a_big ? w_sa : w_sb;
    assign w_diff    = w_e_big - w_e_small;

    // Bits pushed past the round position fold into sticky.
    assign w_ext     = {w_m_small, 3'b000};
    assign w_shifted = w_ext >> w_diff;
    assign w_mask    = ~({MX{1'b1}} << w_diff);
    assign w_aligned = (w_diff >= E_WIDTH'(M_WIDTH + 3))
                     ? {{(MX-1){1'b0}}, |w_m_small}
                     : {w_shifted[MX-1:1], w_shifted[0] | (|(w_ext & w_mask))};

    always_comb begin
        w_s1         = '0;
        w_s1.sign    = w_inf ? (w_inf_a ? w_sa : w_sb) : w_s_big;
        w_s1.eff_sub = w_sa != w_sb;
        w_s1.exp     = w_e_big;
        w_s1.m_big   = {w_m_big, 3'b000};
        w_s1.m_small = w_aligned;
        w_s1.nan     = w_nan;
        w_s1.inf     = w_inf;
    end

    // ---------------- stage 2: magnitude add or subtract ----------------
    logic [MX:0] w_sum;
    fp_s2_t      w_s2;

    assign w_sum = r_s1.eff_sub ? ({1'b0, r_s1.m_big} - {1'b0, r_s1.m_small})
                                : ({1'b0, r_s1.m_big} + {1'b0, r_s1.m_small});

    // Exact cancellation of opposite signs yields +0.
    always_comb begin
        w_s2      = '0;
        w_s2.sign = (r_s1.eff_sub && (w_sum == '0) && !r_s1.inf) ? 1'b0 : r_s1.sign;
        w_s2.exp  = r_s1.exp;
        w_s2.sum  = w_sum;
        w_s2.nan  = r_s1.nan;
        w_s2.inf  = r_s1.inf;
    end

    // ---------------- stage 3: normalize, round, pack ----------------
    logic [LZW-1:0]     w_lzc;
    logic               w_carry, w_rnd_up, w_hidden;
    logic [E1-1:0]      w_exp_m1, w_lz, w_sh, w_exp_n, w_exp_r;
    logic [MX-1:0]      w_norm;
    logic [M_WIDTH+1:0] w_mant;
    logic [M_WIDTH-1:0] w_frac;
    logic [W-1:0]       w_res;

    fp_lzc #(.W(MX), .CW(LZW)) u_lzc (
        .i_data  (r_s2.sum[MX-1:0]),
        .o_cnt_c (w_lzc)
    );

    assign w_carry  = r_s2.sum[MX];
    assign w_exp_m1 = (r_s2.exp == '0) ? '0 : E1'(r_s2.exp) - E1'(1);
    assign w_lz     = E1'(w_lzc);
    assign w_sh     = (w_lz < w_exp_m1) ? w_lz : w_exp_m1;
    assign w_norm   = w_carry ? {r_s2.sum[MX:2], r_s2.sum[1] | r_s2.sum[0]}
                              : (r_s2.sum[MX-1:0] << w_sh);
    assign w_exp_n  = w_carry ? E1'(r_s2.exp) + E1'(1) : E1'(r_s2.exp) - w_sh;

    assign w_rnd_up = w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]);
    assign w_mant   = {1'b0, w_norm[MX-1:3]} + (M_WIDTH+2)'(w_rnd_up);
    assign w_exp_r  = w_mant[M_WIDTH+1] ? w_exp_n + E1'(1) : w_exp_n;
    assign w_frac   = w_mant[M_WIDTH+1] ? w_mant[M_WIDTH:1] : w_mant[M_WIDTH-1:0];
    assign w_hidden = w_mant[M_WIDTH+1] | w_mant[M_WIDTH];

    // A clear hidden bit means a subnormal (or zero) result with exponent field 0.
    always_comb begin
        w_res = {r_s2.sign, (w_hidden ? w_exp_r[E_WIDTH-1:0] : {E_WIDTH{1'b0}}), w_frac};
        if (r_s2.nan) begin
            w_res = QNAN;
        end else if (r_s2.inf || (w_hidden && (w_exp_r >= E1'(EXP_MAX)))) begin
            w_res = {r_s2.sign, {E_WIDTH{1'b1}}, {M_WIDTH{1'b0}}};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_a  <= '0;
            r_b  <= '0;
            r_s1 <= '0;
            r_s2 <= '0;
            res  <= '0;
        end else begin
            r_a  <= A;
            r_b  <= B;
            r_s1 <= w_s1;
            r_s2 <= w_s2;
            res  <= w_res;
        end
    end

endmodule

// File: tb/tb_fp_adder.sv
// Streams directed and random operand pairs through fp_adder and compares every result
// against an exact-arithmetic reference model.
module tb_fp_adder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] A   = '0;
    logic [31:0] B   = '0;
    logic [31:0] res;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_q[$];
    int          id_q[$];

    always #5 clk = ~clk;

    fp_adder dut (
        .clk (clk),
        .rst (rst),
        .A   (A),
        .B   (B),
        .res (res)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, want);
        end
    endtask

    // Exact sum of the two values, then IEEE round-to-nearest-even into single precision.
    function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b);
        logic [127:0] big_v, small_v, tot, sig, rem, half;
        logic [23:0]  ma, mb, mbig, msmall;
        logic         sbig;
        int           ea, eb, ebig, esmall, diff, base, p, er, sh;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        if ((ea == 255 && a[22:0] != 0) || (eb == 255 && b[22:0] != 0)) return 32'h7FC00000;
        if (ea == 255 && eb == 255) return (a[31] == b[31]) ? a : 32'h7FC00000;
        if (ea == 255) return a;
        if (eb == 255) return b;
        ma = {ea != 0, a[22:0]};
        mb = {eb != 0, b[22:0]};
        if (ea == 0) ea = 1;
        if (eb == 0) eb = 1;
        if (a[30:0] >= b[30:0]) begin
            ebig = ea; esmall = eb; mbig = ma; msmall = mb; sbig = a[31];
        end else begin
            ebig = eb; esmall = ea; mbig = mb; msmall = ma; sbig = b[31];
        end
        diff = ebig - esmall;
        // Beyond 60 bits apart the small operand only matters as a nonzero crumb.
        if (diff > 60) begin
            big_v   = 128'(mbig) << 60;
            small_v = (msmall != 0) ? 128'd1 : 128'd0;
            base    = ebig - 60;
        end else begin
            big_v   = 128'(mbig) << diff;
            small_v = 128'(msmall);
            base    = esmall;
        end
        tot = (a[31] == b[31]) ? big_v + small_v : big_v - small_v;
        if (tot == 0) return {a[31] & b[31], 31'b0};
        p = 0;
        for (int i = 0; i < 128; i++) if (tot[i]) p = i;
        er = base + p - 23;
        if (er < 1) er = 1;
        sh = er - base;
        if (sh <= 0) begin
            sig = tot << (-sh);
        end else begin
            sig  = tot >> sh;
            rem  = tot & ((128'd1 << sh) - 128'd1);
            half = 128'd1 << (sh - 1);
            if (rem > half || (rem == half && sig[0])) sig = sig + 128'd1;
        end
        if (sig == (128'd1 << 24)) begin
            sig = sig >> 1;
            er  = er + 1;
        end
        if (!sig[23]) return {sbig, 8'h00, sig[22:0]};
        if (er >= 255) return {sbig, 8'hFF, 23'b0};
        return {sbig, 8'(er), sig[22:0]};
    endfunction

    function automatic logic [31:0] rand_op(input int cls, input int e_ref);
        logic [31:0] r;
        logic [31:0] sp[6];
        int          e;
        r  = $urandom();
        sp = '{32'h7F800000, 32'hFF800000, 32'h7FC00000, 32'hFFA00001, 32'h00000000, 32'h80000000};
        case (cls)
            0:       return r;
            1:       return {r[31], 8'h00, r[22:0]};
            2:       return sp[$urandom_range(0, 5)];
            default: begin
                e = e_ref + int'($urandom_range(0, 8)) - 4;
                if (e < 1) e = 1;
                if (e > 254) e = 254;
                return {r[31], 8'(e), r[22:0]};
            end
        endcase
    endfunction

    // One operand pair per falling edge; the result surfaces four falling edges later.
    task automatic step(input logic [31:0] a, input logic [31:0] b, input logic [31:0] want, input int id);
        @(negedge clk);
        if (exp_q.size() == 4) begin
            check_eq((id_q[0] < 0) ? "fill" : $sformatf("op%0d", id_q[0]), res, exp_q[0]);
            void'(exp_q.pop_front());
            void'(id_q.pop_front());
        end
        A = a;
        B = b;
        exp_q.push_back(want);
        id_q.push_back(id);
    endtask

    task automatic preload_zeros();
        exp_q.delete();
        id_q.delete();
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(32'h0);
            id_q.push_back(-1);
        end
    endtask

    logic [31:0] dir_a[21] = '{
        32'd1, 32'd2, 32'd3, 32'd4, 32'd84, 32'd92, 32'd72, 32'd93,
        32'h3F800000, 32'h40400000, 32'h3F800000,
        32'h3F800000, 32'h3F800000, 32'h3F800001,
        32'h7F7FFFFF, 32'h7F800000, 32'h7FC00001, 32'hFF800000,
        32'h007FFFFF, 32'h00800000, 32'h80000000};
    logic [31:0] dir_b[21] = '{
        32'd102, 32'd73, 32'd92, 32'd40, 32'd5, 32'd6, 32'd7, 32'd8,
        32'h3F800000, 32'hBF800000, 32'hBF800000,
        32'h33800000, 32'h33800001, 32'h33800000,
        32'h7F7FFFFF, 32'hFF800000, 32'h3F800000, 32'h42000000,
        32'h00000001, 32'h80000001, 32'h80000000};
    logic [31:0] dir_r[21] = '{
        32'd103, 32'd75, 32'd95, 32'd44, 32'd89, 32'd98, 32'd79, 32'd101,
        32'h40000000, 32'h40000000, 32'h00000000,
        32'h3F800000, 32'h3F800001, 32'h3F800002,
        32'h7F800000, 32'h7FC00000, 32'h7FC00000, 32'hFF800000,
        32'h00800000, 32'h007FFFFF, 32'h80000000};

    initial begin
        logic [31:0] a, b, r;
        int          id;
        id = 0;

        repeat (2) @(negedge clk);
        check_eq("reset", res, 32'h0);
        @(posedge clk);
        #2 rst = 1'b1;
        preload_zeros();

        for (int i = 0; i < 21; i++) begin
            step(dir_a[i], dir_b[i], dir_r[i], id); id++;
        end
        // Same directed pairs in swapped order must give identical words.
        for (int i = 0; i < 21; i++) begin
            step(dir_b[i], dir_a[i], dir_r[i], id); id++;
        end

        for (int i = 0; i < 700; i++) begin
            int e_ref;
            e_ref = int'($urandom_range(1, 254));
            a = rand_op(int'($urandom_range(0, 6)), e_ref);
            b = ($urandom_range(0, 9) == 0) ? {~a[31], a[30:0]} : rand_op(int'($urandom_range(0, 6)), e_ref);
            r = ref_add(a, b);
            step(a, b, r, id); id++;
            step(b, a, r, id); id++;
        end

        // Three operations in flight when reset hits between edges.
        for (int i = 0; i < 3; i++) begin
            step(32'h3F800000, 32'h40000000, 32'h40400000, id); id++;
        end
        @(posedge clk);
        #2 rst = 1'b0;
        #1 check_eq("rst_async", res, 32'h0);
        exp_q.delete();
        id_q.delete();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            A = $urandom();
            B = $urandom();
            check_eq("rst_hold", res, 32'h0);
        end
        @(posedge clk);
        #2 rst = 1'b1;
        preload_zeros();
        for (int i = 0; i < 8; i++) begin
            step(dir_a[i], dir_b[i], dir_r[i], id); id++;
        end
        for (int i = 0; i < 4; i++) begin
            step(32'h0, 32'h0, 32'h0, id); id++;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
